// File: rtl/lfsr_range_sampler.sv
// Masked rejection sampler turning LFSR state into uniform values in [0, range-1].
// Accepted value visible one cycle after evaluation; a full FIFO stalls evaluation.
module lfsr_range_sampler #(
  parameter int WIDTH = 26,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:WIDTH]   lfsr_q,
  input  logic             cfg_load,
  input  logic [OUT_W-1:0] cfg_range,
  input  logic [3:0]       cfg_stride,
  input  logic             run,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             cfg_err,
  output logic [15:0]      reject_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;
  state_t state, state_nxt;

  logic [OUT_W-1:0] range_r, mask, cand;
  logic [3:0]       stride_r, skip_cnt;
  logic             cfg_ok, mask_done, enter_run;
  logic             eval, accept, do_push, do_rej, do_pop, fifo_full;
  logic [OUT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             unused_hi;

  // Upper state bits do not feed the sampler.
  assign unused_hi = ^lfsr_q[1:WIDTH-OUT_W];

  assign cand      = lfsr_q[WIDTH-OUT_W+1:WIDTH] & mask;
  assign mask_done = (mask >= (range_r - OUT_W'(1)));
  assign fifo_full = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign busy      = (state == SETUP);
  assign do_pop    = out_valid && out_ready && !cfg_load;
  assign eval      = (state == RUN) && run && (skip_cnt == 4'd0) && !fifo_full && !cfg_load;
  assign accept    = (cand < range_r);
  assign do_push   = eval && accept;
  assign do_rej    = eval && !accept;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    enter_run = 1'b0;
    case (state)
      IDLE: begin
        if (run && cfg_ok) begin
          state_nxt = RUN;
          enter_run = 1'b1;
        end
      end
      SETUP: begin
        if (mask_done) begin
          if (run) begin
            state_nxt = RUN;
            enter_run = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      RUN: begin
        if (!run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A new configuration overrides whatever the FSM was about to do.
    if (cfg_load) begin
      state_nxt = (cfg_range != '0) ? SETUP : IDLE;
      enter_run = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      range_r    <= '0;
      stride_r   <= '0;
      mask       <= '0;
      skip_cnt   <= '0;
      cfg_ok     <= 1'b0;
      cfg_err    <= 1'b0;
      reject_cnt <= '0;
    end else if (cfg_load) begin
      range_r    <= cfg_range;
      stride_r   <= cfg_stride;
      mask       <= '0;
      skip_cnt   <= '0;
      cfg_ok     <= 1'b0;
      cfg_err    <= (cfg_range == '0);
      reject_cnt <= '0;
    end else begin
      if (state == SETUP) begin
        if (mask_done) cfg_ok <= 1'b1;
        else           mask   <= {mask[OUT_W-2:0], 1'b1};
      end
      // Counter parks at zero while the FIFO is full so evaluation resumes immediately.
      if (enter_run) begin
        skip_cnt <= stride_r;
      end else if ((state == RUN) && run) begin
        if (skip_cnt != 4'd0) skip_cnt <= skip_cnt - 4'd1;
        else if (!fifo_full)  skip_cnt <= stride_r;
      end
      if (do_rej && (reject_cnt != 16'hFFFF)) reject_cnt <= reject_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) fifo_mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else if (cfg_load) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Head register: next entry, or the value being pushed when it becomes the head.
      if (do_pop) begin
        if (count > CNT_W'(1)) out_data <= fifo_mem[rd_ptr + PTR_W'(1)];
        else if (do_push)      out_data <= cand;
      end else if (!out_valid && do_push) begin
        out_data <= cand;
      end
    end
  end

endmodule
